// File: rtl/tree_pkg.sv
// rtl/tree_pkg.sv - node word field layout, walk states and the double ordering key
package tree_pkg;

    localparam int NODE_ID_LSB = 96;
    localparam int NODE_ID_W   = 12;
    localparam int FIDX_LSB    = 92;
    localparam int FIDX_W      = 4;
    localparam int THR_LSB     = 28;
    localparam int THR_W       = 64;
    localparam int LEFT_LSB    = 16;
    localparam int RIGHT_LSB   = 4;
    localparam int CHILD_W     = 12;
    localparam int LEAF_BIT    = 0;
    localparam int CLASS_LSB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } walk_state_e;

    // Maps an IEEE-754 double onto an unsigned key whose ordering follows the
    // numeric ordering, with -0 placed just below +0.
    function automatic logic [63:0] dbl_key(input logic [63:0] x);
        return x[63] ? ~x : (x ^ 64'h8000_0000_0000_0000);
    endfunction

endpackage

// File: rtl/dbl_le_cmp.sv
// rtl/dbl_le_cmp.sv - combinational a <= b for IEEE-754 doubles via the ordering key
module dbl_le_cmp
    import tree_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        le
);

    assign le = (dbl_key(a) <= dbl_key(b));

endmodule

// File: rtl/tree_walk_ctrl.sv
// rtl/tree_walk_ctrl.sv - decision tree walker over a registered node ROM; option TREE_WALK_DEPTH_GUARD_EN
module tree_walk_ctrl
    import tree_pkg::*;
#(
    parameter int NODE_WIDTH   = 120,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_W       = 64,
    parameter int CLASS_W      = 8,
    parameter int ROOT_ADDR    = 0,
    parameter int MAX_DEPTH    = 64
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_FEATURES*FEAT_W-1:0] features,
    output logic [ADDR_WIDTH-1:0]          rom_addr,
    input  logic [NODE_WIDTH-1:0]          rom_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CLASS_W-1:0]             out_class,
    output logic                           out_err,
    output logic                           busy
);

    walk_state_e                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]          ptr, ptr_nxt;
    logic [NUM_FEATURES*FEAT_W-1:0] feat_reg;
    logic [CLASS_W-1:0]             res_class, res_class_nxt;
    logic                           res_err, res_err_nxt;

    logic [NODE_ID_W-1:0] node_id;
    logic [FIDX_W-1:0]    feat_idx;
    logic [THR_W-1:0]     threshold;
    logic [CHILD_W-1:0]   left_child, right_child, child;
    logic                 is_leaf;
    logic [CLASS_W-1:0]   leaf_class;
    logic [FEAT_W-1:0]    feat_sel;
    logic                 go_left, fidx_bad, child_hi_bad, id_bad, depth_hit, node_err;
    logic                 unused_rom_bits;

    assign node_id         = rom_data[NODE_ID_LSB +: NODE_ID_W];
    assign feat_idx        = rom_data[FIDX_LSB +: FIDX_W];
    assign threshold       = rom_data[THR_LSB +: THR_W];
    assign left_child      = rom_data[LEFT_LSB +: CHILD_W];
    assign right_child     = rom_data[RIGHT_LSB +: CHILD_W];
    assign is_leaf         = rom_data[LEAF_BIT];
    assign leaf_class      = rom_data[CLASS_LSB +: CLASS_W];
    assign unused_rom_bits = ^{rom_data[NODE_WIDTH-1:NODE_ID_LSB+NODE_ID_W], rom_data[3:1]};

    // Select the feature named by the node; out-of-range indices read as zero and are flagged.
    always_comb begin
        feat_sel = '0;
        for (int k = 0; k < NUM_FEATURES; k++) begin
            if (int'(feat_idx) == k) feat_sel = feat_reg[k*FEAT_W +: FEAT_W];
        end
    end

    dbl_le_cmp u_cmp (
        .a  (feat_sel),
        .b  (threshold),
        .le (go_left)
    );

    assign child        = go_left ? left_child : right_child;
    assign fidx_bad     = (int'(feat_idx) >= NUM_FEATURES);
    assign child_hi_bad = ((child >> ADDR_WIDTH) != '0);
    assign id_bad       = (node_id[ADDR_WIDTH-1:0] != ptr) || ((node_id >> ADDR_WIDTH) != '0);
    assign node_err     = id_bad || (!is_leaf && (child_hi_bad || fidx_bad || depth_hit));

`ifdef TREE_WALK_DEPTH_GUARD_EN
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    logic [DEPTH_W-1:0] depth;

    assign depth_hit = (depth == DEPTH_W'(MAX_DEPTH - 1));

    // Count internal-node visits since the root so a cyclic image is cut off.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            depth <= '0;
        end else if (state == ST_EVAL && !node_err && !is_leaf) begin
            depth <= depth + 1'b1;
        end
    end
`else
    localparam int unused_max_depth = MAX_DEPTH;
    assign depth_hit = 1'b0;
`endif

    // Latch the feature vector on acceptance; the input bus is free afterwards.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) feat_reg <= features;
    end

    // State, node pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= ADDR_WIDTH'(ROOT_ADDR);
            res_class <= '0;
            res_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            res_class <= res_class_nxt;
            res_err   <= res_err_nxt;
        end
    end

    // Walk sequencing: one FETCH cycle covers the ROM latency, EVAL steps or finishes.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        res_class_nxt = res_class;
        res_err_nxt   = res_err;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    ptr_nxt   = ADDR_WIDTH'(ROOT_ADDR);
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_EVAL;
            ST_EVAL: begin
                if (node_err) begin
                    res_class_nxt = '0;
                    res_err_nxt   = 1'b1;
                    state_nxt     = ST_DONE;
                end else if (is_leaf) begin
                    res_class_nxt = leaf_class;
                    res_err_nxt   = 1'b0;
                    state_nxt     = ST_DONE;
                end else begin
                    ptr_nxt   = child[ADDR_WIDTH-1:0];
                    state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign rom_addr  = ptr;
    assign out_class = res_class;
    assign out_err   = res_err;

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// tb/tb_tree_walk_ctrl.sv - directed self-checking bench for tree_walk_ctrl
module tb_tree_walk_ctrl;

    localparam int NODE_WIDTH   = 120;
    localparam int ADDR_WIDTH   = 10;
    localparam int NUM_FEATURES = 16;
    localparam int FEAT_W       = 64;
    localparam int CLASS_W      = 8;

    localparam logic [63:0] D_P0   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] D_M0   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] D_P1   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D_M1   = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] D_P2   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D_HALF = 64'h3FE0_0000_0000_0000;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_FEATURES*FEAT_W-1:0] features;
    logic [ADDR_WIDTH-1:0]          rom_addr;
    logic [NODE_WIDTH-1:0]          rom_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CLASS_W-1:0]             out_class;
    logic                           out_err;
    logic                           busy;

    logic [NODE_WIDTH-1:0] rom [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    tree_walk_ctrl #(
        .NODE_WIDTH  (NODE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_FEATURES(NUM_FEATURES),
        .FEAT_W      (FEAT_W),
        .CLASS_W     (CLASS_W),
        .ROOT_ADDR   (0),
        .MAX_DEPTH   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .features (features),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_err  (out_err),
        .busy     (busy)
    );

    function automatic logic [NODE_WIDTH-1:0] mk_node(input int id, input int fidx,
            input logic [63:0] thr, input int left, input int right, input logic leaf);
        logic [NODE_WIDTH-1:0] n;
        n          = '0;
        n[107:96]  = 12'(id);
        n[95:92]   = 4'(fidx);
        n[91:28]   = thr;
        n[27:16]   = 12'(left);
        n[15:4]    = 12'(right);
        n[0]       = leaf;
        return n;
    endfunction

    function automatic logic [NODE_WIDTH-1:0] mk_leaf(input int id, input int cls);
        return mk_node(id, 0, D_P0, 0, cls, 1'b1);
    endfunction

    task automatic put_feat(input int k, input logic [63:0] v);
        features[k*FEAT_W +: FEAT_W] = v;
    endtask

    task automatic build_depth3();
        rom[0]  = mk_node(0, 0, D_P1,   1, 20, 1'b0);
        rom[1]  = mk_node(1, 1, D_P2,   2, 21, 1'b0);
        rom[2]  = mk_node(2, 2, D_HALF, 3, 22, 1'b0);
        rom[3]  = mk_leaf(3, 8'h07);
        rom[20] = mk_leaf(20, 8'h20);
        rom[21] = mk_leaf(21, 8'h21);
        rom[22] = mk_leaf(22, 8'h22);
    endtask

    task automatic start_walk();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        features = ~features;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; features = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_class !== 8'h00) begin failures++; $display("FAIL reset_out_class got=%0h exp=0", out_class); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (rom_addr !== 10'd0) begin failures++; $display("FAIL reset_rom_addr got=%0h exp=0", rom_addr); end
    endtask

    task automatic test_root_leaf();
        int lat;
        rom[0] = mk_leaf(0, 5);
        start_walk();
        checks++; if ({busy, in_ready} !== 2'b10) begin failures++; $display("FAIL root_busy got=%0b exp=10", {busy, in_ready}); end
        wait_result(lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL root_latency got=%0d exp=2", lat); end
        checks++; if ({out_err, out_class} !== {1'b0, 8'd5}) begin failures++; $display("FAIL root_result got=%0h exp=5", {out_err, out_class}); end
        pop_result();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL root_after_pop got=%0b exp=10", {in_ready, out_valid}); end
    endtask

    task automatic test_depth3_equal();
        logic [63:0] f0 [3] = '{D_P1, D_P1, D_P2};
        logic [63:0] f1 [3] = '{D_M1, D_P2, D_P1};
        logic [63:0] f2 [3] = '{D_HALF, D_P1, D_P1};
        int          ec [3] = '{8'h07, 8'h22, 8'h20};
        int          el [3] = '{8, 8, 4};
        int lat;
        build_depth3();
        for (int i = 0; i < 3; i++) begin
            features = {NUM_FEATURES{64'h7FF8_DEAD_BEEF_0001}};
            put_feat(0, f0[i]); put_feat(1, f1[i]); put_feat(2, f2[i]);
            start_walk();
            wait_result(lat);
            checks++; if (lat != el[i]) begin failures++; $display("FAIL depth3_latency[%0d] got=%0d exp=%0d", i, lat, el[i]); end
            checks++; if ({out_err, out_class} !== {1'b0, 8'(ec[i])}) begin failures++; $display("FAIL depth3_result[%0d] got=%0h exp=%0h", i, {out_err, out_class}, ec[i]); end
            pop_result();
        end
    endtask

    task automatic test_signed_zero();
        logic [63:0] f3 [4] = '{D_M1, D_M0, D_P1, D_P0};
        int          ec [4] = '{8'h11, 8'h11, 8'h12, 8'h11};
        int lat;
        rom[0] = mk_node(0, 3, D_P0, 1, 2, 1'b0);
        rom[1] = mk_leaf(1, 8'h11);
        rom[2] = mk_leaf(2, 8'h12);
        for (int i = 0; i < 4; i++) begin
            features = '0;
            put_feat(3, f3[i]);
            start_walk();
            wait_result(lat);
            checks++; if (lat != 4) begin failures++; $display("FAIL zero_latency[%0d] got=%0d exp=4", i, lat); end
            checks++; if ({out_err, out_class} !== {1'b0, 8'(ec[i])}) begin failures++; $display("FAIL zero_result[%0d] got=%0h exp=%0h", i, {out_err, out_class}, ec[i]); end
            pop_result();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        rom[0] = mk_leaf(0, 9);
        start_walk();
        wait_result(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready, out_class} !== {1'b1, 1'b0, 8'd9}) begin
                failures++; $display("FAIL hold_cycle[%0d] got=%0h exp=209", c, {out_valid, in_ready, out_class});
            end
        end
        pop_result();
        checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin failures++; $display("FAIL hold_release got=%0b exp=100", {in_ready, out_valid, busy}); end
        start_walk();
        wait_result(lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        checks++; if (out_class !== 8'd9) begin failures++; $display("FAIL b2b_class got=%0h exp=9", out_class); end
        pop_result();
    endtask

    task automatic test_errors();
        logic [NODE_WIDTH-1:0] node [4];
        int lat;
        node[0] = mk_node(5, 0, D_P1, 1, 2, 1'b0);
        node[1] = mk_node(12'h400, 0, D_P1, 1, 2, 1'b0);
        node[2] = mk_node(0, 0, D_P1, 12'h401, 2, 1'b0);
        node[3] = mk_leaf(3, 9);
        for (int i = 0; i < 4; i++) begin
            rom[0] = node[i];
            features = '0;
            put_feat(0, D_P1);
            start_walk();
            wait_result(lat);
            checks++; if (lat != 2) begin failures++; $display("FAIL err_latency[%0d] got=%0d exp=2", i, lat); end
            checks++; if ({out_err, out_class} !== {1'b1, 8'd0}) begin failures++; $display("FAIL err_result[%0d] got=%0h exp=100", i, {out_err, out_class}); end
            pop_result();
        end
    endtask

    task automatic test_reset_mid_walk();
        int lat;
        logic saw_valid;
        build_depth3();
        features = '0;
        put_feat(0, D_P1); put_feat(1, D_M1); put_feat(2, D_HALF);
        start_walk();
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({busy, rom_addr} !== {1'b1, 10'd2}) begin failures++; $display("FAIL midrst_pre got=%0h exp=402", {busy, rom_addr}); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({in_ready, out_valid, busy, rom_addr} !== {3'b100, 10'd0}) begin
            failures++; $display("FAIL midrst_idle got=%0h exp=1000", {in_ready, out_valid, busy, rom_addr});
        end
        saw_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale_valid got=1 exp=0"); end
        features = '0;
        put_feat(0, D_P1); put_feat(1, D_M1); put_feat(2, D_HALF);
        start_walk();
        wait_result(lat);
        checks++; if (lat != 8) begin failures++; $display("FAIL midrst_latency got=%0d exp=8", lat); end
        checks++; if ({out_err, out_class} !== {1'b0, 8'h07}) begin failures++; $display("FAIL midrst_result got=%0h exp=7", {out_err, out_class}); end
        pop_result();
    endtask

    task automatic test_self_loop();
        int lat;
        rom[0] = mk_node(0, 0, D_P1, 0, 0, 1'b0);
        features = '0;
        put_feat(0, D_HALF);
        start_walk();
`ifdef TREE_WALK_DEPTH_GUARD_EN
        wait_result(lat);
        checks++; if (lat != 16) begin failures++; $display("FAIL loop_guard_latency got=%0d exp=16", lat); end
        checks++; if ({out_err, out_class} !== {1'b1, 8'd0}) begin failures++; $display("FAIL loop_guard_result got=%0h exp=100", {out_err, out_class}); end
        pop_result();
`else
        begin
            logic bad;
            bad = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            end
            checks++; if (bad !== 1'b0) begin failures++; $display("FAIL loop_runs_on got=1 exp=0"); end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checks++; if ({in_ready, busy} !== 2'b10) begin failures++; $display("FAIL loop_reset got=%0b exp=10", {in_ready, busy}); end
        end
`endif
        rom[0] = mk_leaf(0, 3);
        start_walk();
        wait_result(lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL loop_recover_latency got=%0d exp=2", lat); end
        checks++; if ({out_err, out_class} !== {1'b0, 8'd3}) begin failures++; $display("FAIL loop_recover_result got=%0h exp=3", {out_err, out_class}); end
        pop_result();
    endtask

    initial begin
        test_reset();
        test_root_leaf();
        test_depth3_equal();
        test_signed_zero();
        test_back_to_back();
        test_errors();
        test_reset_mid_walk();
        test_self_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tree_walk_ctrl.md
# tree_walk_ctrl

Sequencer for one decision tree in the inference engine. It accepts a feature vector, walks a registered-output node ROM (`tree_rom_*`) from the root to a leaf, and returns the leaf class. Each node visit issues one ROM address, waits out the ROM's 1-cycle read latency, then evaluates. There is one instance per tree; a downstream vote block consumes the results.

## Interface
Parameters:
- `NODE_WIDTH`, default 120: ROM word width.
- `ADDR_WIDTH`, default 10: ROM address width.
- `NUM_FEATURES`, default 16: number of features in the input vector.
- `FEAT_W`, default 64: feature width, IEEE-754 double.
- `CLASS_W`, default 8: output class width.
- `ROOT_ADDR`, default 0: address of the root node.
- `MAX_DEPTH`, default 64: node-visit limit (used only with the depth guard).

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: feature vector valid.
- `in_ready`, output, 1: block is idle and can accept.
- `features`, input, NUM_FEATURES*FEAT_W: feature vector; feature k is at `[k*FEAT_W +: FEAT_W]`.
- `rom_addr`, output, ADDR_WIDTH: node address to the ROM.
- `rom_data`, input, NODE_WIDTH: node word, valid one cycle after `rom_addr`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_class`, output, CLASS_W: leaf class.
- `out_err`, output, 1: walk aborted; `out_class` is 0.
- `busy`, output, 1: walk in progress.

## Operation
Node word fields:
- [107:96]: node_id.
- [95:92]: feature_idx.
- [91:28]: threshold (double).
- [27:16]: left child.
- [15:4]: right child.
- [0]: is_leaf.
- Leaf class is [CLASS_W+3:4].
- All other bits are ignored.

Input capture:
- On `in_valid && in_ready`, `features` is latched into an internal register.
- The input bus is don't-care after acceptance.

Comparison:
- Take the left child if feature ≤ threshold; otherwise take the right child.
- Both values are mapped to an unsigned key: if the sign bit is 0, key = x ^ 2^63; otherwise key = ~x. The keys are compared unsigned.
- Consequences: -0 < +0, and equal values go left. NaN is not specified.

Error conditions. Any of these ends the walk with `out_err`=1 and `out_class`=0:
- node_id[ADDR_WIDTH-1:0] differs from the current pointer.
- node_id or a selected child has nonzero bits above ADDR_WIDTH.
- feature_idx ≥ NUM_FEATURES at an internal node.

State machine:
- IDLE: `in_ready`=1. On accept, set ptr = ROOT_ADDR, depth = 0, then go to FETCH.
- FETCH: `rom_addr` = ptr, held stable. Go to EVAL.
- EVAL: `rom_data` is valid.
  - On an error, or on a leaf: load the result and go to DONE.
  - Otherwise: ptr = chosen child, depth + 1, then go to FETCH.
- DONE: `out_valid`=1 and the result is held stable. When `out_ready`=1, go to IDLE.

Outputs:
- `rom_addr` is driven from the ptr register in every state.
- `busy` is 1 in FETCH, EVAL and DONE.

## Timing
Reset values:
- State = IDLE, ptr = ROOT_ADDR, depth = 0.
- `in_ready`=1 (after the first cycle, because the reset is synchronous).
- `out_valid`=0, `out_class`=0, `out_err`=0, `busy`=0.
- `rom_addr` = ROOT_ADDR.

Latency, for a leaf at depth d (d internal nodes above it), with the accept on edge 0:
- `out_valid` first rises in cycle 2(d+1)+1.
- A root-leaf tree gives `out_valid` in cycle 3.

Handshake and throughput:
- `in_ready` is low from the accept until the cycle after the result handshake.
- Input and output are never active in the same cycle, so back-to-back walks are separated by one IDLE cycle.
- `out_valid` holds, with the result stable, for as long as `out_ready` is 0.
- `out_ready` is ignored outside DONE.

Reset during a walk:
- `rst` in any state returns to IDLE on the next edge.
- No result is produced and no stale `out_valid` appears.

## Configuration
Macro: `TREE_WALK_DEPTH_GUARD_EN`.
- Defined: in EVAL, an internal node reached with depth == MAX_DEPTH-1 ends the walk with `out_err`=1, which catches cyclic ROM images.
- Undefined: no depth counter is synthesised, `MAX_DEPTH` is unused, and a cyclic image walks forever (reset recovers it).

## Structure
Package `tree_pkg`:
- Node field bit positions and widths.
- The state enum (IDLE/FETCH/EVAL/DONE).
- The `dbl_key` mapping as a function.

Sub-module `dbl_le_cmp`: combinational feature ≤ threshold using the key mapping. It is reused by future multi-tree schedulers.

## Test plan
- Root-leaf ROM (rom[0].is_leaf=1, class 5) → `out_valid` in cycle 3 with `out_class`=5 and `out_err`=0.
- Depth-3 path with feature exactly equal to a threshold → the left branch is taken at that node, and the expected class appears at cycle 9.
- Negative feature -1.0 against threshold +0.0, and feature -0.0 against threshold +0.0 → both go left; feature +1.0 goes right.
- `out_ready` held at 0 for 10 cycles in DONE → `out_valid` and `out_class` stay stable, `in_ready` stays 0, and IDLE follows one cycle after `out_ready` rises.
- `rst` asserted during EVAL at depth 2 → next cycle is IDLE with `out_valid`=0 and `rom_addr`=ROOT_ADDR; a new walk then completes correctly.
- Self-looping node (left child = its own address):
  - with `TREE_WALK_DEPTH_GUARD_EN` defined and MAX_DEPTH=8 → `out_err`=1 after 8 visits;
  - separately, a node_id mismatch → `out_err`=1 at the first EVAL.
